// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared types and constants for the IF-stage fetch controller.
// Holds the FSM encoding, reset PC default and bus response codes.
package ifu_fetch_ctrl_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [XLEN-1:0] ALIGN_MASK   = 32'hFFFF_FFFC;
    localparam logic [XLEN-1:0] INST_BYTES   = 32'd4;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + INST_BYTES;
    endfunction

endpackage

// File: rtl/ifu_fetch_ctrl_if.sv
// Fetch controller bundle: redirect inputs, instruction read port
// and the IF/ID presentation handshake.
interface ifu_fetch_ctrl_if;
    import ifu_fetch_ctrl_pkg::*;

    logic            trap_redir_valid;
    logic [XLEN-1:0] trap_redir_pc;
    logic            br_redir_valid;
    logic [XLEN-1:0] br_redir_pc;

    logic            inst_ar_valid;
    logic [XLEN-1:0] inst_ar_addr;
    logic            inst_ar_ready;
    logic            inst_r_valid;
    logic [XLEN-1:0] inst_r_data;
    logic [1:0]      inst_r_resp;
    logic            inst_r_ready;

    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_inst;
    logic            if_fault;
    logic            if_ready;

    modport master (
        input  trap_redir_valid,
        input  trap_redir_pc,
        input  br_redir_valid,
        input  br_redir_pc,
        output inst_ar_valid,
        output inst_ar_addr,
        input  inst_ar_ready,
        input  inst_r_valid,
        input  inst_r_data,
        input  inst_r_resp,
        output inst_r_ready,
        output if_valid,
        output if_pc,
        output if_inst,
        output if_fault,
        input  if_ready
    );

    modport slave (
        output trap_redir_valid,
        output trap_redir_pc,
        output br_redir_valid,
        output br_redir_pc,
        input  inst_ar_valid,
        input  inst_ar_addr,
        output inst_ar_ready,
        output inst_r_valid,
        output inst_r_data,
        output inst_r_resp,
        input  inst_r_ready,
        input  if_valid,
        input  if_pc,
        input  if_inst,
        input  if_fault,
        output if_ready
    );

endinterface

// File: rtl/ifu_fetch_ctrl_redir_arb.sv
// Redirect source select: trap/mret outranks branch/jump.
// Targets are word aligned here so the FSM only ever sees legal PCs.
module ifu_fetch_ctrl_redir_arb
    import ifu_fetch_ctrl_pkg::*;
(
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic            br_valid_i,
    input  logic [XLEN-1:0] br_pc_i,
    output logic            redir_valid_o,
    output logic [XLEN-1:0] redir_pc_o
);

    logic [XLEN-1:0] sel_pc;

    always_comb begin
        sel_pc = br_pc_i;
        if (trap_valid_i) begin
            sel_pc = trap_pc_i;
        end
        redir_valid_o = trap_valid_i | br_valid_i;
        redir_pc_o    = sel_pc & ALIGN_MASK;
    end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// IF-stage fetch sequencer: single-outstanding instruction reads,
// redirect squash and a one-entry hold buffer toward IF/ID.
module ifu_fetch_ctrl
    import ifu_fetch_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input logic             clk,
    input logic             rst_n,
    ifu_fetch_ctrl_if.master bus
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            pend_valid_q, pend_valid_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] buf_pc_q, buf_pc_d;
    logic [XLEN-1:0] buf_inst_q, buf_inst_d;
    logic            buf_fault_q, buf_fault_d;

    logic            redir_valid;
    logic [XLEN-1:0] redir_pc;
    logic            ar_fire;

    ifu_fetch_ctrl_redir_arb u_redir_arb (
        .trap_valid_i  (bus.trap_redir_valid),
        .trap_pc_i     (bus.trap_redir_pc),
        .br_valid_i    (bus.br_redir_valid),
        .br_pc_i       (bus.br_redir_pc),
        .redir_valid_o (redir_valid),
        .redir_pc_o    (redir_pc)
    );

    assign ar_fire = (state_q == REQ) && bus.inst_ar_ready;

    assign bus.inst_ar_valid = (state_q == REQ);
    assign bus.inst_ar_addr  = fetch_pc_q;
    assign bus.inst_r_ready  = (state_q == WAIT);
    assign bus.if_valid      = (state_q == HOLD);
    assign bus.if_pc         = buf_pc_q;
    assign bus.if_inst       = buf_inst_q;
    assign bus.if_fault      = buf_fault_q;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        kill_d       = kill_q;
        buf_pc_d     = buf_pc_q;
        buf_inst_d   = buf_inst_q;
        buf_fault_d  = buf_fault_q;

        unique case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redir_valid) begin
                    fetch_pc_d = redir_pc;
                end
            end
            REQ: begin
                // The address cannot be retracted, so a redirect here
                // only marks the in-flight read for discard.
                if (ar_fire) begin
                    state_d      = WAIT;
                    pend_valid_d = 1'b0;
                    if (redir_valid) begin
                        kill_d     = 1'b1;
                        fetch_pc_d = redir_pc;
                    end else if (pend_valid_q) begin
                        kill_d     = 1'b1;
                        fetch_pc_d = pend_pc_q;
                    end
                end else if (redir_valid) begin
                    pend_valid_d = 1'b1;
                    pend_pc_d    = redir_pc;
                end
            end
            WAIT: begin
                if (redir_valid) begin
                    kill_d     = 1'b1;
                    fetch_pc_d = redir_pc;
                end
                if (bus.inst_r_valid) begin
                    if (kill_q || redir_valid) begin
                        state_d = REQ;
                        kill_d  = 1'b0;
                    end else begin
                        state_d     = HOLD;
                        buf_pc_d    = fetch_pc_q;
                        buf_inst_d  = bus.inst_r_data;
                        buf_fault_d = (bus.inst_r_resp != RESP_OKAY);
                    end
                end
            end
            HOLD: begin
                // Redirect beats acceptance; IF/ID flushes on redirect.
                if (redir_valid) begin
                    state_d    = REQ;
                    fetch_pc_d = redir_pc;
                end else if (bus.if_ready) begin
                    state_d    = REQ;
                    fetch_pc_d = pc_next(buf_pc_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= RESET_PC;
            kill_q       <= 1'b0;
            buf_pc_q     <= RESET_PC;
            buf_inst_q   <= '0;
            buf_fault_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
            kill_q       <= kill_d;
            buf_pc_q     <= buf_pc_d;
            buf_inst_q   <= buf_inst_d;
            buf_fault_q  <= buf_fault_d;
        end
    end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for the fetch controller: memory stub, transaction-level
// model checked every cycle, and directed redirect/stall scenarios.
module tb_ifu_fetch_ctrl;
    import ifu_fetch_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifu_fetch_ctrl_if bus ();

    ifu_fetch_ctrl #(.RESET_PC(32'h8000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    // memory stub: one read at a time, cfg_lat idle cycles before data
    logic        mem_out;
    logic [31:0] mem_addr;
    int          mem_lat;
    int          cfg_lat = 0;
    logic [31:0] fault_addr = 32'h1234_5678;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_out  <= 1'b0;
            mem_addr <= '0;
            mem_lat  <= 0;
        end else if (!mem_out && bus.inst_ar_valid && bus.inst_ar_ready) begin
            mem_out  <= 1'b1;
            mem_addr <= bus.inst_ar_addr;
            mem_lat  <= cfg_lat;
        end else if (mem_out) begin
            if (bus.inst_r_valid && bus.inst_r_ready) mem_out <= 1'b0;
            else if (mem_lat > 0) mem_lat <= mem_lat - 1;
        end
    end

    assign bus.inst_r_valid = mem_out && (mem_lat == 0);
    assign bus.inst_r_data  = memfn(mem_addr);
    assign bus.inst_r_resp  = (mem_addr == fault_addr) ? 2'b10 : 2'b00;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } acc_t;

    logic [31:0] req_log[$];
    int          req_cyc[$];
    acc_t        acc_log[$];

    function automatic logic [31:0] get_req(input int i);
        return (i < req_log.size()) ? req_log[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic int get_cyc(input int i);
        return (i < req_cyc.size()) ? req_cyc[i] : -100;
    endfunction

    function automatic acc_t get_acc(input int i);
        acc_t z;
        z = '{pc: 32'hDEAD_BEEF, inst: 32'hDEAD_BEEF, fault: 1'b1};
        return (i < acc_log.size()) ? acc_log[i] : z;
    endfunction

    // transaction model: what the fetch port must look like this cycle
    logic        m_first, m_req, m_kill, m_out, m_hold;
    logic [31:0] m_pc, m_req_addr, m_out_addr;
    acc_t        m_h;

    initial begin
        logic        redir;
        logic [31:0] tgt, addr;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_first = 1'b1;
                m_req   = 1'b0;
                m_kill  = 1'b0;
                m_out   = 1'b0;
                m_hold  = 1'b0;
                m_pc    = 32'h8000_0000;
            end else begin
                addr = m_req ? m_req_addr : m_pc;
                chk("ar_valid", {31'd0, bus.inst_ar_valid},
                    {31'd0, !m_first && !m_out && !m_hold});
                if (!m_first && !m_out && !m_hold)
                    chk("ar_addr", bus.inst_ar_addr, addr);
                chk("r_ready", {31'd0, bus.inst_r_ready}, {31'd0, m_out});
                chk("if_valid", {31'd0, bus.if_valid}, {31'd0, m_hold});
                if (m_hold) begin
                    chk("if_pc", bus.if_pc, m_h.pc);
                    chk("if_inst", bus.if_inst, m_h.inst);
                    chk("if_fault", {31'd0, bus.if_fault}, {31'd0, m_h.fault});
                end

                redir = bus.trap_redir_valid | bus.br_redir_valid;
                tgt = bus.trap_redir_valid ? bus.trap_redir_pc : bus.br_redir_pc;
                tgt = {tgt[31:2], 2'b00};

                if (bus.inst_ar_valid && bus.inst_ar_ready) begin
                    req_log.push_back(bus.inst_ar_addr);
                    req_cyc.push_back(cyc);
                end
                if (bus.if_valid && bus.if_ready && !redir)
                    acc_log.push_back('{pc: bus.if_pc, inst: bus.if_inst,
                                        fault: bus.if_fault});

                if (m_first) begin
                    m_first = 1'b0;
                    if (redir) m_pc = tgt;
                end else if (!m_out && !m_hold) begin
                    if (redir) begin
                        m_kill = 1'b1;
                        m_pc   = tgt;
                    end
                    if (bus.inst_ar_ready) begin
                        m_out      = 1'b1;
                        m_req      = 1'b0;
                        m_out_addr = addr;
                    end else begin
                        m_req      = 1'b1;
                        m_req_addr = addr;
                    end
                end else if (m_out) begin
                    if (redir) begin
                        m_kill = 1'b1;
                        m_pc   = tgt;
                    end
                    if (bus.inst_r_valid) begin
                        m_out = 1'b0;
                        if (!m_kill) begin
                            m_hold = 1'b1;
                            m_h = '{pc: m_out_addr, inst: memfn(m_out_addr),
                                    fault: (m_out_addr == fault_addr)};
                        end
                        m_kill = 1'b0;
                    end
                end else begin
                    if (redir) begin
                        m_hold = 1'b0;
                        m_pc   = tgt;
                    end else if (bus.if_ready) begin
                        m_hold = 1'b0;
                        m_pc   = m_h.pc + 32'd4;
                    end
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic cond(input int k);
        case (k)
            0: return bus.if_valid;
            1: return bus.inst_r_ready;
            default: return bus.inst_ar_valid;
        endcase
    endfunction

    task automatic wait_st(input string nm, input int k);
        int n;
        n = 0;
        while (!cond(k) && n < 50) begin
            step();
            n++;
        end
        total++;
        if (n >= 50) begin
            bad++;
            $display("FAIL %s: timeout after %0d cycles, want state %0d", nm, n, k);
        end
    endtask

    int   n0, a0;
    logic [31:0] a_old;

    initial begin
        bus.trap_redir_valid = 1'b0;
        bus.trap_redir_pc    = '0;
        bus.br_redir_valid   = 1'b0;
        bus.br_redir_pc      = '0;
        bus.inst_ar_ready    = 1'b1;
        bus.if_ready         = 1'b1;
        step(3);

        chk("rst_ar_valid", {31'd0, bus.inst_ar_valid}, 32'd0);
        chk("rst_r_ready", {31'd0, bus.inst_r_ready}, 32'd0);
        chk("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("rst_if_pc", bus.if_pc, 32'h8000_0000);
        chk("rst_if_inst", bus.if_inst, 32'd0);
        chk("rst_if_fault", {31'd0, bus.if_fault}, 32'd0);

        // streaming with zero-wait memory
        rst_n = 1'b1;
        step(11);
        chk("t1_req0", get_req(0), 32'h8000_0000);
        chk("t1_req1", get_req(1), 32'h8000_0004);
        chk("t1_req2", get_req(2), 32'h8000_0008);
        chk("t1_gap01", get_cyc(1) - get_cyc(0), 32'd3);
        chk("t1_gap12", get_cyc(2) - get_cyc(1), 32'd3);
        chk("t1_inst0", get_acc(0).inst, 32'hDA5A_5A5A);
        chk("t1_pc1", get_acc(1).pc, 32'h8000_0004);

        // IF/ID stall for 5 cycles in HOLD
        bus.if_ready = 1'b0;
        wait_st("t2_hold", 0);
        step(5);
        chk("t2_pc", bus.if_pc, 32'h8000_000C);
        chk("t2_inst", bus.if_inst, 32'hDA5A_5A56);
        n0 = req_log.size();
        bus.if_ready = 1'b1;
        step(4);
        chk("t2_next", get_req(n0), 32'h8000_0010);

        // branch during WAIT, data arrives next cycle
        cfg_lat = 1;
        wait_st("t3_wait", 1);
        n0 = req_log.size();
        a0 = acc_log.size();
        bus.br_redir_valid = 1'b1;
        bus.br_redir_pc    = 32'h8000_0100;
        step();
        bus.br_redir_valid = 1'b0;
        step(8);
        chk("t3_req", get_req(n0), 32'h8000_0100);
        chk("t3_acc", get_acc(a0).pc, 32'h8000_0100);

        // trap and branch together in HOLD while IF/ID accepts
        cfg_lat = 0;
        bus.if_ready = 1'b0;
        wait_st("t4_hold", 0);
        a0 = acc_log.size();
        bus.if_ready         = 1'b1;
        bus.trap_redir_valid = 1'b1;
        bus.trap_redir_pc    = 32'h8000_0200;
        bus.br_redir_valid   = 1'b1;
        bus.br_redir_pc      = 32'h8000_0100;
        step();
        bus.trap_redir_valid = 1'b0;
        bus.br_redir_valid   = 1'b0;
        chk("t4_drop", {31'd0, bus.if_valid}, 32'd0);
        n0 = req_log.size();
        step(6);
        chk("t4_req", get_req(n0), 32'h8000_0200);
        chk("t4_acc", get_acc(a0).pc, 32'h8000_0200);

        // ar_ready low for 4 cycles, branch on the second
        bus.if_ready = 1'b0;
        wait_st("t5_hold", 0);
        bus.if_ready      = 1'b1;
        bus.inst_ar_ready = 1'b0;
        n0 = req_log.size();
        step();
        a_old = get_acc(acc_log.size() - 1).pc + 32'd4;
        step();
        bus.br_redir_valid = 1'b1;
        bus.br_redir_pc    = 32'h8000_0040;
        step();
        bus.br_redir_valid = 1'b0;
        step(2);
        bus.inst_ar_ready = 1'b1;
        step(6);
        chk("t5_old", get_req(n0), a_old);
        chk("t5_new", get_req(n0 + 1), 32'h8000_0040);

        // error response marks the presented instruction
        bus.if_ready = 1'b0;
        wait_st("t6_hold", 0);
        fault_addr = 32'h8000_0300;
        bus.trap_redir_valid = 1'b1;
        bus.trap_redir_pc    = 32'h8000_0300;
        step();
        bus.trap_redir_valid = 1'b0;
        wait_st("t6_valid", 0);
        chk("t6_fault", {31'd0, bus.if_fault}, 32'd1);
        chk("t6_pc", bus.if_pc, 32'h8000_0300);
        chk("t6_inst", bus.if_inst, 32'hDA5A_595A);
        bus.if_ready = 1'b1;
        step(4);

        // misaligned target aligned down, then PC wraps to zero
        bus.if_ready = 1'b0;
        wait_st("t7_hold", 0);
        bus.if_ready         = 1'b1;
        bus.trap_redir_valid = 1'b1;
        bus.trap_redir_pc    = 32'hFFFF_FFFE;
        step();
        bus.trap_redir_valid = 1'b0;
        n0 = req_log.size();
        step(8);
        chk("t7_top", get_req(n0), 32'hFFFF_FFFC);
        chk("t7_wrap", get_req(n0 + 1), 32'h0000_0000);

        // reset in the middle of a read
        cfg_lat = 3;
        wait_st("t8_wait", 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t8_ar_valid", {31'd0, bus.inst_ar_valid}, 32'd0);
        chk("t8_r_ready", {31'd0, bus.inst_r_ready}, 32'd0);
        chk("t8_if_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("t8_if_pc", bus.if_pc, 32'h8000_0000);
        step(2);
        rst_n = 1'b1;
        n0 = req_log.size();
        step(4);
        chk("t8_req", get_req(n0), 32'h8000_0000);
        step(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
